// File: rtl/udm_uart_tx_if.sv
// Byte write handshake between a requester (master) and the UDM UART transmitter (slave).
interface udm_uart_tx_if;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_ack;

   modport master (output tx_req, output tx_data, input tx_ack);
   modport slave  (input tx_req, input tx_data, output tx_ack);
endinterface

// File: rtl/udm_uart_tx.sv
// UDM link UART transmitter: byte FIFO feeding an 8N1/8E1/8O1 serialiser, LSB first.
// Bit period and parity mode are latched per frame when the byte is popped.
module udm_uart_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1,
   parameter int DIV_WIDTH  = 32
) (
   input  logic                          clk_i,
   input  logic                          arst_n_i,
   input  logic [DIV_WIDTH-1:0]          bitperiod_i,
   input  logic [1:0]                    parity_cfg_i,
   udm_uart_tx_if.slave                  req_if,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] period_q, period_in;
   logic [2:0]           bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 tx_q, tx_d;
   logic [7:0]           shift_q;
   logic                 par_q, paren_q;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_ptr_q, rd_ptr_q;
   logic                 full, empty, push, pop, shift_en, bit_end, last_stop;
   logic [7:0]           head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign push         = req_if.tx_req & ~full;
   assign req_if.tx_ack = push;
   assign fifo_level_o = wr_ptr_q - rd_ptr_q;
   assign head         = mem_q[rd_ptr_q[AW-1:0]];

   assign period_in = (bitperiod_i == '0) ? DIV_WIDTH'(1) : bitperiod_i;
   assign bit_end   = (cnt_q == '0);
   assign last_stop = (STOP_BITS == 1) || stop_q;
   assign tx_o      = tx_q;
   assign busy_o    = (state_q != ST_IDLE) || !empty;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
      end
   end

   // Frame settings are captured together with the byte so mid-frame input changes cannot leak in.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= req_if.tx_data;
      if (pop) begin
         shift_q  <= head;
         period_q <= period_in;
         paren_q  <= (parity_cfg_i == 2'b01) || (parity_cfg_i == 2'b10);
         par_q    <= (^head) ^ (parity_cfg_i == 2'b10);
      end else if (shift_en) begin
         shift_q <= {1'b0, shift_q[7:1]};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               tx_d    = 1'b0;
               cnt_d   = period_in - DIV_WIDTH'(1);
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               cnt_d   = period_q - DIV_WIDTH'(1);
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = period_q - DIV_WIDTH'(1);
               if (bit_q == 3'd7) begin
                  stop_d  = 1'b0;
                  tx_d    = paren_q ? par_q : 1'b1;
                  state_d = paren_q ? ST_PARITY : ST_STOP;
               end else begin
                  tx_d     = shift_q[1];
                  shift_en = 1'b1;
                  bit_d    = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               cnt_d   = period_q - DIV_WIDTH'(1);
               stop_d  = 1'b0;
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         ST_STOP: begin
            if (!bit_end) begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end else if (!last_stop) begin
               stop_d = 1'b1;
               cnt_d  = period_q - DIV_WIDTH'(1);
            end else if (!empty) begin
               // Back-to-back: the next start bit follows the last stop cycle directly.
               pop     = 1'b1;
               tx_d    = 1'b0;
               cnt_d   = period_in - DIV_WIDTH'(1);
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end
endmodule
